// File: rtl/can_pkg.sv
// Shared CAN definitions for the transmit-side error/overload generator and the bus monitor.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLAG,
    SUPERPOS,
    DELIM
  } can_state_e;

  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  localparam int unsigned CAN_FLAG_BITS    = 6;
  localparam int unsigned CAN_DELIM_BITS   = 8;
  localparam int unsigned CAN_MAX_SUPERPOS = 7;

  function automatic int unsigned can_max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/can_bit_counter.sv
// Saturating bit-time counter. Clear and increment together load 1, so the caller can
// restart a run with the current bit already counted.
module can_bit_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d, base;

  // Next count: optional clear, then saturating increment.
  always_comb begin
    base    = clr ? '0 : count_q;
    count_d = base;
    if (inc && (base != '1)) begin
      count_d = base + WIDTH'(1);
    end
  end

  // Count register, only updated on enabled (bit-time) clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/can_err_ovld_frame_tx.sv
// CAN error/overload frame transmitter: drives the flag, tracks superposition from
// other nodes, then waits out the recessive delimiter.
module can_err_ovld_frame_tx
  import can_pkg::*;
#(
  parameter int unsigned FLAG_BITS    = CAN_FLAG_BITS,
  parameter int unsigned DELIM_BITS   = CAN_DELIM_BITS,
  parameter int unsigned MAX_SUPERPOS = CAN_MAX_SUPERPOS
) (
  input  logic clk,
  input  logic reset,
  input  logic sp_tick,
  input  logic rx,
  input  logic req_error,
  input  logic req_overload,
  input  logic err_passive,
  output logic tx,
  output logic busy,
  output logic frame_is_ovld,
  output logic done,
  output logic bit_err,
  output logic stuck_err
);

  localparam int unsigned CNT_MAX = can_max3(FLAG_BITS, DELIM_BITS, MAX_SUPERPOS);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] FLAG_LAST  = CW'(FLAG_BITS - 1);
  localparam logic [CW-1:0] DELIM_LAST = CW'(DELIM_BITS - 1);
  localparam logic [CW-1:0] SUP_MAX    = CW'(MAX_SUPERPOS);

  can_state_e    state_q, state_d;
  logic          tx_q, tx_d;
  logic          ovld_q, ovld_d;
  logic          passive_q, passive_d;
  logic          done_q, done_d;
  logic          bit_err_q, bit_err_d;
  logic          stuck_q, stuck_d;
  logic          cnt_clr, cnt_inc;
  logic [CW-1:0] cnt;

  can_bit_counter #(
    .WIDTH (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (sp_tick),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt)
  );

  // Next-state, counter control and pulse generation; nothing moves without sp_tick.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    ovld_d    = ovld_q;
    passive_d = passive_q;
    done_d    = 1'b0;
    bit_err_d = 1'b0;
    stuck_d   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (sp_tick) begin
      unique case (state_q)
        IDLE: begin
          if (req_error || req_overload) begin
            state_d   = FLAG;
            cnt_clr   = 1'b1;
            ovld_d    = ~req_error;
            // Overload flags are always active.
            passive_d = req_error & err_passive;
            tx_d      = passive_d ? CAN_RECESSIVE : CAN_DOMINANT;
          end
        end
        FLAG: begin
          if (!passive_q && (rx == CAN_RECESSIVE)) begin
            bit_err_d = 1'b1;
            state_d   = IDLE;
            cnt_clr   = 1'b1;
            tx_d      = CAN_RECESSIVE;
          end else if (cnt == FLAG_LAST) begin
            state_d = SUPERPOS;
            cnt_clr = 1'b1;
            tx_d    = CAN_RECESSIVE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        SUPERPOS: begin
          tx_d = CAN_RECESSIVE;
          if (rx == CAN_DOMINANT) begin
            if (cnt >= SUP_MAX) begin
              stuck_d = 1'b1;
              state_d = IDLE;
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end else begin
            // First recessive bit is already delimiter bit 1.
            state_d = DELIM;
            cnt_clr = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        DELIM: begin
          tx_d = CAN_RECESSIVE;
          if (rx == CAN_RECESSIVE) begin
            if (cnt == DELIM_LAST) begin
              done_d  = 1'b1;
              state_d = IDLE;
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end else begin
            // Violating dominant bit counts as the first superposition bit.
            state_d = SUPERPOS;
            cnt_clr = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          tx_d    = CAN_RECESSIVE;
        end
      endcase
    end
  end

  // State, bus drive, latched frame attributes and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= CAN_RECESSIVE;
      ovld_q    <= 1'b0;
      passive_q <= 1'b0;
      done_q    <= 1'b0;
      bit_err_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      ovld_q    <= ovld_d;
      passive_q <= passive_d;
      done_q    <= done_d;
      bit_err_q <= bit_err_d;
      stuck_q   <= stuck_d;
    end
  end

  assign tx            = tx_q;
  assign busy          = (state_q != IDLE);
  assign frame_is_ovld = ovld_q;
  assign done          = done_q;
  assign bit_err       = bit_err_q;
  assign stuck_err     = stuck_q;

endmodule

// File: tb/tb_can_err_ovld_frame_tx.sv
// Bench for can_err_ovld_frame_tx: scenario table, hand sequences, randomized run,
// all checked against a run-length reference model every clock.
module tb_can_err_ovld_frame_tx;

  localparam int FLAG_BITS    = 6;
  localparam int DELIM_BITS   = 8;
  localparam int MAX_SUPERPOS = 7;

  logic clk, reset, sp_tick, rx, req_error, req_overload, err_passive;
  logic tx, busy, frame_is_ovld, done, bit_err, stuck_err;

  int checks   = 0;
  int failures = 0;

  can_err_ovld_frame_tx dut (
    .clk           (clk),
    .reset         (reset),
    .sp_tick       (sp_tick),
    .rx            (rx),
    .req_error     (req_error),
    .req_overload  (req_overload),
    .err_passive   (err_passive),
    .tx            (tx),
    .busy          (busy),
    .frame_is_ovld (frame_is_ovld),
    .done          (done),
    .bit_err       (bit_err),
    .stuck_err     (stuck_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame described as flag bits sent, then runs of dominant/recessive.
  logic m_busy, m_in_flag, m_passive, m_ovld, m_tx;
  logic m_done, m_berr, m_stuck, m_rst;
  int   m_flag_n, m_dom, m_rec;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_done  = 1'b0;
    m_berr  = 1'b0;
    m_stuck = 1'b0;
    m_rst   = reset;
    if (reset) begin
      m_busy = 0; m_in_flag = 0; m_passive = 0; m_ovld = 0; m_tx = 1;
      m_flag_n = 0; m_dom = 0; m_rec = 0;
    end else if (sp_tick) begin
      if (!m_busy) begin
        if (req_error || req_overload) begin
          m_busy = 1; m_in_flag = 1; m_flag_n = 0; m_dom = 0; m_rec = 0;
          m_ovld = !req_error;
          m_passive = req_error && err_passive;
          m_tx = m_passive;
        end
      end else if (m_in_flag) begin
        if (!m_passive && rx) begin
          m_berr = 1; m_busy = 0; m_in_flag = 0; m_tx = 1;
        end else begin
          m_flag_n++;
          if (m_flag_n == FLAG_BITS) begin
            m_in_flag = 0; m_tx = 1;
          end
        end
      end else if (!rx) begin
        m_rec = 0;
        m_dom++;
        if (m_dom > MAX_SUPERPOS) begin
          m_stuck = 1; m_busy = 0;
        end
      end else begin
        m_dom = 0;
        m_rec++;
        if (m_rec == DELIM_BITS) begin
          m_done = 1; m_busy = 0;
        end
      end
    end
  endtask

  // One clock: predict, take the edge, compare just after it.
  task automatic cyc(input logic tick);
    sp_tick = tick;
    model_step();
    @(posedge clk);
    #1;
    chk("tx", tx, m_tx);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("bit_err", bit_err, m_berr);
    chk("stuck_err", stuck_err, m_stuck);
    if (m_busy || m_done || m_rst) chk("frame_is_ovld", frame_is_ovld, m_ovld);
  endtask

  task automatic bit_time();
    cyc(1'b1);
    cyc(1'b0);
  endtask

  // Scenario table: kind 0=done, 1=bit_err, 2=stuck_err; post = rx after flag, LSB first.
  typedef struct {
    logic        req_e;
    logic        req_o;
    logic        pas;
    int          bad;
    logic [31:0] post;
    logic        exp_flag_tx;
    int          exp_ticks;
    int          exp_kind;
    logic        exp_ovld;
  } vec_t;

  vec_t vecs[8];
  int   end_k, kind, bias;
  logic prev_tick, was_busy, tk;

  initial begin
    vecs[0] = '{1, 0, 0, 0, 32'hFFFF_FFFF, 0, 14, 0, 0};  // active error, clean bus
    vecs[1] = '{0, 1, 0, 0, 32'hFFFF_FFF8, 0, 17, 0, 1};  // overload, 3 superposed bits
    vecs[2] = '{1, 0, 0, 3, 32'hFFFF_FFFF, 0, 3, 1, 0};   // recessive on 3rd flag bit
    vecs[3] = '{1, 0, 0, 0, 32'h0000_0000, 0, 14, 2, 0};  // rx stuck dominant
    vecs[4] = '{1, 0, 0, 0, 32'hFFFF_FFEF, 0, 19, 0, 0};  // dominant at delimiter bit 5
    vecs[5] = '{1, 1, 1, 0, 32'hFFFF_FFFF, 1, 14, 0, 0};  // both requests, passive
    vecs[6] = '{0, 1, 1, 0, 32'hFFFF_FFFF, 0, 14, 0, 1};  // overload ignores err_passive
    vecs[7] = '{1, 0, 0, 0, 32'hFFFF_FF80, 0, 21, 0, 0};  // exactly MAX_SUPERPOS dominant

    reset = 1; sp_tick = 0; rx = 1; req_error = 0; req_overload = 0; err_passive = 0;
    cyc(1'b1);
    cyc(1'b0);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ovld", frame_is_ovld, 1'b0);
    reset = 0;
    bit_time();

    foreach (vecs[i]) begin
      req_error = vecs[i].req_e; req_overload = vecs[i].req_o; err_passive = vecs[i].pas;
      rx = 1;
      bit_time();
      req_error = 0; req_overload = 0; err_passive = 0;
      chk($sformatf("vec%0d_accept_busy", i), busy, 1'b1);
      end_k = 0;
      kind  = -1;
      for (int k = 1; k <= 40 && end_k == 0; k++) begin
        if (k <= FLAG_BITS) begin
          chk($sformatf("vec%0d_flag_tx", i), tx, vecs[i].exp_flag_tx);
          rx = (k == vecs[i].bad) ? 1'b1 : vecs[i].exp_flag_tx;
        end else begin
          rx = (k - FLAG_BITS - 1 < 32) ? vecs[i].post[k - FLAG_BITS - 1] : 1'b1;
        end
        cyc(1'b1);
        if (done || bit_err || stuck_err) begin
          end_k = k;
          kind  = done ? 0 : (bit_err ? 1 : 2);
          if (done) chk($sformatf("vec%0d_ovld", i), frame_is_ovld, vecs[i].exp_ovld);
        end
        cyc(1'b0);
      end
      chk_int($sformatf("vec%0d_end_tick", i), end_k, vecs[i].exp_ticks);
      chk_int($sformatf("vec%0d_outcome", i), kind, vecs[i].exp_kind);
      chk($sformatf("vec%0d_idle_tx", i), tx, 1'b1);
      chk($sformatf("vec%0d_idle_busy", i), busy, 1'b0);
      rx = 1;
      bit_time();
    end

    // Reset mid-delimiter, colliding with a tick and a request.
    req_error = 1; rx = 1;
    bit_time();
    req_error = 0;
    for (int k = 1; k <= 9; k++) begin
      rx = (k <= FLAG_BITS) ? 1'b0 : 1'b1;
      bit_time();
    end
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1; req_error = 1; rx = 1;
    cyc(1'b1);
    chk("mid_reset_tx", tx, 1'b1);
    chk("mid_reset_busy", busy, 1'b0);
    chk("mid_reset_done", done, 1'b0);
    chk("mid_reset_ovld", frame_is_ovld, 1'b0);
    reset = 0; req_error = 0;
    bit_time();

    // Without sp_tick nothing advances, even with a bus error present.
    req_error = 1; rx = 0;
    bit_time();
    req_error = 0; rx = 1;
    for (int k = 0; k < 5; k++) cyc(1'b0);
    chk("hold_busy", busy, 1'b1);
    chk("hold_tx", tx, 1'b0);
    cyc(1'b1);
    chk("hold_then_bit_err", bit_err, 1'b1);
    cyc(1'b0);

    // Randomized traffic against the model.
    prev_tick = 0;
    bias = 10;
    for (int n = 0; n < 6000; n++) begin
      reset        = ($urandom_range(0, 499) == 0);
      req_error    = ($urandom_range(0, 3) == 0);
      req_overload = ($urandom_range(0, 3) == 0);
      err_passive  = $urandom_range(0, 1);
      if (m_busy && m_in_flag && !m_passive) rx = ($urandom_range(0, 19) == 0);
      else if (m_busy) rx = ($urandom_range(0, 99) < bias) ? 1'b0 : 1'b1;
      else rx = $urandom_range(0, 1);
      tk = !prev_tick && ($urandom_range(0, 1) == 0);
      was_busy = m_busy;
      cyc(tk);
      prev_tick = tk;
      if (!was_busy && m_busy) begin
        case ($urandom_range(0, 2))
          0: bias = 10;
          1: bias = 40;
          default: bias = 92;
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_err_ovld_frame_tx.md
Name: can_err_ovld_frame_tx

Overview:
- Transmit-side generator for CAN error and overload frames; companion to the bus-side frame monitor.
- On request, drives the 6-bit flag onto tx, then tracks flag superposition from other nodes on rx, then drives the 8-bit recessive delimiter.
- Advances once per bit-time on the sample-point strobe; reports completion to the MAC state machine.

Parameters:
- FLAG_BITS, 6, flag length in bit-times.
- DELIM_BITS, 8, delimiter length in bit-times, counting the first recessive bit seen.
- MAX_SUPERPOS, 7, maximum dominant bits tolerated on rx after own flag before stuck error.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- sp_tick  in  1  one-clk pulse at bit sample point; all bit-level actions only on clk edges with sp_tick=1
- rx  in  1  sampled bus level (0=dominant)
- req_error  in  1  request error frame; level-sampled on sp_tick in IDLE
- req_overload  in  1  request overload frame; level-sampled on sp_tick in IDLE
- err_passive  in  1  node error-passive; latched at frame start; passive error flag is recessive
- tx  out  1  bus drive (1=recessive)
- busy  out  1  high in any state except IDLE
- frame_is_ovld  out  1  latched frame type, valid while busy and on done
- done  out  1  one-clk pulse on clean completion
- bit_err  out  1  one-clk pulse: active flag bit driven dominant but rx read recessive
- stuck_err  out  1  one-clk pulse: superposition exceeded MAX_SUPERPOS

Behaviour:
- Reset: state=IDLE, tx=1, busy=0, done=0, bit_err=0, stuck_err=0, frame_is_ovld=0, counter=0. Reset wins over sp_tick and requests in the same cycle, and aborts any frame mid-operation.
- Counter width: $clog2(max(FLAG_BITS,DELIM_BITS,MAX_SUPERPOS)+1). Counter is cleared on every state change.
- IDLE:
  - On sp_tick with req_error=1 or req_overload=1: enter FLAG.
  - If both requests are high, error has priority and frame_is_ovld=0.
  - Latch err_passive; it is forced to 0 for overload frames.
  - tx is updated on the same edge: 0, or 1 if passive.
- FLAG:
  - tx=0 for active flag, tx=1 for passive flag.
  - Each sp_tick increments the counter.
  - Active flag with rx=1 on sp_tick: pulse bit_err, abort to IDLE, tx=1.
  - When counter reaches FLAG_BITS-1 on sp_tick: enter SUPERPOS and set tx=1.
  - Latency: exactly FLAG_BITS sp_ticks of driven flag.
- SUPERPOS:
  - tx=1.
  - sp_tick with rx=0: increment counter.
  - If counter would exceed MAX_SUPERPOS: pulse stuck_err and go to IDLE.
  - sp_tick with rx=1: this is delimiter bit 1; enter DELIM with counter=1.
- DELIM:
  - tx=1.
  - sp_tick with rx=1: increment counter; at count DELIM_BITS go to IDLE and pulse done on that same edge.
  - sp_tick with rx=0: delimiter violated; return to SUPERPOS with counter=1 (that dominant bit is counted).
- Requests arriving while busy are ignored and not queued.
- Minimum frame: FLAG_BITS + DELIM_BITS sp_ticks from request acceptance to done (14 at defaults).
- sp_tick low: state, tx, and counter hold. done, bit_err, and stuck_err are low except for their single pulse cycle.

Decomposition:
- Shared package can_pkg:
  - state enum {IDLE, FLAG, SUPERPOS, DELIM}
  - constants CAN_DOMINANT=0, CAN_RECESSIVE=1
  - default flag/delimiter lengths
- One natural sub-module: can_bit_counter (saturating up-counter with clear and enable=sp_tick), shared with the receive-side monitor.

Test Plan:
- Active error, clean bus (rx follows tx) -> tx=0 for 6 ticks, then 1; done pulses on the 14th sp_tick after acceptance; bit_err=0.
- Overload with 3 extra dominant rx bits after flag -> tx=1 from tick 7; done after 6+3+8=17 ticks; frame_is_ovld=1.
- Active flag, rx=1 on 3rd flag tick -> bit_err pulse on that tick; busy=0 and tx=1 next cycle; no done.
- rx held 0 after flag -> stuck_err pulse on the 8th superposition tick; return to IDLE.
- Dominant rx at delimiter bit 5 -> back to SUPERPOS; 8 further recessive ticks are required before done.
- req_error and req_overload together, err_passive=1 -> error frame, tx stays 1 throughout flag, frame_is_ovld=0; reset asserted mid-DELIM -> all outputs at reset values next clk.
